// File: rtl/pong_pkg.sv
// Shared Pong video-timing constants and the vblank scheduler state encoding.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_GRANT = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_TOTAL   = 800;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_TOTAL   = 525;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest pending bit at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         pending,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic [N_REQ-1:0]         pick,
    output logic                     any
);

    logic [2*N_REQ-1:0] dbl_s;
    logic [2*N_REQ-1:0] back_s;
    logic [N_REQ-1:0]   rot_s;
    logic [N_REQ-1:0]   first_s;

    // Rotate so rr_ptr sits at bit 0, isolate the lowest set bit, rotate back.
    assign dbl_s   = {pending, pending} >> rr_ptr;
    assign rot_s   = dbl_s[N_REQ-1:0];
    assign first_s = rot_s & (~rot_s + N_REQ'(1));
    assign back_s  = {first_s, first_s} << rr_ptr;
    assign pick    = back_s[2*N_REQ-1:N_REQ];
    assign any     = |pending;

endmodule

// File: rtl/vblank_scheduler.sv
// Hands the vertical-blanking window to one game-update client at a time,
// round-robin, with a per-grant cycle budget and sticky error flags.
module vblank_scheduler
    import pong_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int VD      = 480,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [9:0]       pixel_y,
    input  logic             video_on,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    input  logic             clr_err,
    output logic [N_REQ-1:0] grant,
    output logic             frame_tick,
    output logic             busy,
    output logic             overrun,
    output logic [N_REQ-1:0] timeout_err,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int PW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT);

    sched_state_e     state_r, state_s;
    logic [N_REQ-1:0] grant_r, grant_s;
    logic [N_REQ-1:0] served_r, served_s;
    logic [PW-1:0]    rr_ptr_r, rr_ptr_s;
    logic [TW-1:0]    timer_r, timer_s;
    logic             first_r, first_s;
    logic             vb_q_r;
    logic             tick_r, busy_r, overrun_r;
    logic [N_REQ-1:0] terr_r;
    logic [CNT_W-1:0] cnt_r;

    logic             vb_s, open_s, close_s, done_hit_s, any_s, cnt_inc_s, ov_set_s;
    logic [N_REQ-1:0] pick_s, te_set_s;

    assign vb_s       = (pixel_y >= 10'(VD)) & ~video_on;
    assign open_s     = vb_s & ~vb_q_r;
    assign close_s    = ~vb_s & vb_q_r;
    assign done_hit_s = |(done & grant_r);

    rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
        .pending (req & ~served_r),
        .rr_ptr  (rr_ptr_r),
        .pick    (pick_s),
        .any     (any_s)
    );

    // Next-state, grant, served-mask and error-set decisions.
    always_comb begin
        state_s   = state_r;
        grant_s   = grant_r;
        served_s  = served_r;
        rr_ptr_s  = rr_ptr_r;
        timer_s   = timer_r;
        first_s   = first_r;
        cnt_inc_s = 1'b0;
        ov_set_s  = 1'b0;
        te_set_s  = '0;
        case (state_r)
            ST_IDLE: begin
                if (open_s) begin
                    state_s   = ST_ARB;
                    served_s  = '0;
                    cnt_inc_s = 1'b1;
                    first_s   = 1'b1;
                    // The very first frame after reset starts at client 0.
                    if (first_r) begin
                        rr_ptr_s = (rr_ptr_r == PW'(N_REQ - 1)) ? '0 : rr_ptr_r + PW'(1);
                    end else begin
                        rr_ptr_s = rr_ptr_r;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (close_s) begin
                    state_s = ST_IDLE;
                end else if (!any_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_GRANT;
                    grant_s = pick_s;
                    timer_s = '0;
                end
            end
            ST_GRANT: begin
                if (close_s) begin
                    state_s = ST_IDLE;
                    grant_s = '0;
                    if (done_hit_s) begin
                        served_s = served_r | grant_r;
                    end else begin
                        ov_set_s = 1'b1;
                    end
                end else if (done_hit_s) begin
                    state_s  = ST_ARB;
                    grant_s  = '0;
                    served_s = served_r | grant_r;
                end else if (timer_r == TW'(TIMEOUT - 1)) begin
                    state_s  = ST_ARB;
                    grant_s  = '0;
                    served_s = served_r | grant_r;
                    te_set_s = grant_r;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            default: begin
                if (close_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
        endcase
    end

    // State and output registers; a fresh error outranks a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            grant_r   <= '0;
            served_r  <= '0;
            rr_ptr_r  <= '0;
            timer_r   <= '0;
            first_r   <= 1'b0;
            vb_q_r    <= 1'b0;
            tick_r    <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
            terr_r    <= '0;
            cnt_r     <= '0;
        end else begin
            state_r   <= state_s;
            grant_r   <= grant_s;
            served_r  <= served_s;
            rr_ptr_r  <= rr_ptr_s;
            timer_r   <= timer_s;
            first_r   <= first_s;
            vb_q_r    <= vb_s;
            tick_r    <= open_s;
            busy_r    <= (state_s != ST_IDLE);
            overrun_r <= ov_set_s | (overrun_r & ~clr_err);
            terr_r    <= te_set_s | (clr_err ? '0 : terr_r);
            cnt_r     <= cnt_inc_s ? cnt_r + CNT_W'(1) : cnt_r;
        end
    end

    assign grant       = grant_r;
    assign frame_tick  = tick_r;
    assign busy        = busy_r;
    assign overrun     = overrun_r;
    assign timeout_err = terr_r;
    assign frame_cnt   = cnt_r;

endmodule

// File: tb/tb_vblank_scheduler.sv
// Randomized frames and client behaviour checked each cycle against a
// transaction-level model of the vblank window sharing rules.
module tb_vblank_scheduler;

    localparam int N  = 4;
    localparam int VD = 480;
    localparam int TO = 16;
    localparam int CW = 8;

    localparam int P_IDLE = 0;
    localparam int P_ARB  = 1;
    localparam int P_OWN  = 2;
    localparam int P_FIN  = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [9:0]    pixel_y;
    logic          video_on;
    logic [N-1:0]  req, done;
    logic          clr_err;
    logic [N-1:0]  grant, timeout_err;
    logic          frame_tick, busy, overrun;
    logic [CW-1:0] frame_cnt;

    always #5 clk = ~clk;

    vblank_scheduler #(.N_REQ(N), .VD(VD), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pixel_y     (pixel_y),
        .video_on    (video_on),
        .req         (req),
        .done        (done),
        .clr_err     (clr_err),
        .grant       (grant),
        .frame_tick  (frame_tick),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .frame_cnt   (frame_cnt)
    );

    int checks = 0;
    int errors = 0;

    // model state
    int           m_phase, m_owner, m_held, m_ptr, e_cnt;
    bit           m_first, m_vbp;
    bit [N-1:0]   m_served;
    bit [N-1:0]   e_grant, e_te;
    bit           e_tick, e_busy, e_ov;
    int           dly[N];
    logic [N-1:0] cur_req;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_val("grant",       32'(grant),       32'(e_grant));
        check_val("frame_tick",  32'(frame_tick),  32'(e_tick));
        check_val("busy",        32'(busy),        32'(e_busy));
        check_val("overrun",     32'(overrun),     32'(e_ov));
        check_val("timeout_err", 32'(timeout_err), 32'(e_te));
        check_val("frame_cnt",   32'(frame_cnt),   32'(e_cnt));
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_owner = -1; m_held = 0; m_ptr = 0; e_cnt = 0;
        m_first = 1'b0; m_vbp = 1'b0; m_served = '0;
        e_grant = '0; e_te = '0; e_tick = 1'b0; e_busy = 1'b0; e_ov = 1'b0;
    endtask

    task automatic model_update(input logic [9:0] py, input logic von, input logic [N-1:0] rq,
                                input logic [N-1:0] dn, input logic clr);
        bit vb, open, close, new_ov;
        bit [N-1:0] new_te, pend;
        vb = (int'(py) >= VD) && !von;
        open = vb && !m_vbp;
        close = !vb && m_vbp;
        m_vbp = vb;
        new_ov = 1'b0;
        new_te = '0;
        e_tick = open;
        case (m_phase)
            P_IDLE: if (open) begin
                e_cnt = (e_cnt + 1) % (1 << CW);
                m_served = '0;
                if (m_first) m_ptr = (m_ptr + 1) % N;
                m_first = 1'b1;
                m_phase = P_ARB;
            end
            P_ARB: if (close) m_phase = P_IDLE;
                else begin
                    pend = rq & ~m_served;
                    m_owner = -1;
                    for (int k = 0; k < N; k++)
                        if (m_owner < 0 && pend[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                    if (m_owner < 0) m_phase = P_FIN;
                    else begin m_held = 0; m_phase = P_OWN; end
                end
            P_OWN: if (close) begin
                    if (dn[m_owner]) m_served[m_owner] = 1'b1;
                    else new_ov = 1'b1;
                    m_owner = -1; m_phase = P_IDLE;
                end else if (dn[m_owner]) begin
                    m_served[m_owner] = 1'b1; m_owner = -1; m_phase = P_ARB;
                end else if (m_held == TO - 1) begin
                    m_served[m_owner] = 1'b1; new_te[m_owner] = 1'b1;
                    m_owner = -1; m_phase = P_ARB;
                end else m_held++;
            default: if (close) m_phase = P_IDLE;
        endcase
        e_ov = new_ov ? 1'b1 : (clr ? 1'b0 : e_ov);
        e_te = new_te | (clr ? '0 : e_te);
        e_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        e_busy = (m_phase != P_IDLE);
    endtask

    task automatic step(input logic [9:0] py, input logic von);
        logic [N-1:0] dn;
        logic clr;
        dn = '0;
        if (m_phase == P_OWN && m_held == dly[m_owner]) dn[m_owner] = 1'b1;
        if ($urandom_range(0, 7) == 0) dn = dn | (N'($urandom) & ~e_grant);
        clr = ($urandom_range(0, 15) == 0);
        if (m_phase == P_OWN && m_held == TO - 1 && $urandom_range(0, 1) == 1) clr = 1'b1;
        if ($urandom_range(0, 31) == 0) cur_req = N'($urandom);
        pixel_y = py; video_on = von; req = cur_req; done = dn; clr_err = clr;
        @(posedge clk);
        model_update(py, von, cur_req, dn, clr);
        #1;
        compare_all();
    endtask

    // Asynchronous reset asserted between clock edges while a client holds a grant.
    task automatic mid_grant_reset();
        #2 reset_n = 1'b0;
        #1 model_reset();
        compare_all();
        @(posedge clk);
        #1 compare_all();
        #1 reset_n = 1'b1;
    endtask

    initial begin
        bit did_rst;
        int vis, blank;
        did_rst = 1'b0;
        pixel_y = 10'd0; video_on = 1'b1; req = '0; done = '0; clr_err = 1'b0;
        cur_req = '0;
        reset_n = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) dly[i] = 0;
        #12;
        compare_all();
        reset_n = 1'b1;
        for (int f = 0; f < 300; f++) begin
            if ($urandom_range(0, 3) != 0) cur_req = N'($urandom);
            for (int i = 0; i < N; i++)
                dly[i] = ($urandom_range(0, 4) == 0) ? 100 : int'($urandom_range(0, 9));
            vis = $urandom_range(2, 5);
            for (int v = 0; v < vis; v++)
                step(10'($urandom_range(0, VD - 1)), 1'($urandom_range(0, 1)));
            blank = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 8) : $urandom_range(20, 90);
            for (int b = 0; b < blank; b++) begin
                if (b == 0 && $urandom_range(0, 1) == 1) step(10'(VD), 1'b0);
                else step(10'($urandom_range(VD, 524)), 1'b0);
                if (!did_rst && f >= 100 && m_phase == P_OWN) begin
                    mid_grant_reset();
                    did_rst = 1'b1;
                end
            end
        end
        check_val("reset_seen", 32'(did_rst), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
